// File: rtl/npc_wb_pkg.sv
// Shared definitions for the writeback unit: default widths, the load-size
// encoding and the writeback FSM state enum.
package npc_wb_pkg;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        LD_BYTE = 2'd0,
        LD_HALF = 2'd1,
        LD_WORD = 2'd2,
        LD_RSVD = 2'd3
    } ld_size_e;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_MEM = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_unit_if.sv
// Execute / memory-response / register-file-write bundle for wb_unit.
// master = execute stage and memory side, slave = the writeback unit.
interface wb_unit_if #(
    parameter int ADDR_WIDTH = npc_wb_pkg::ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = npc_wb_pkg::DATA_WIDTH_DEF
);
    logic                  ex_valid;
    logic                  ex_ready;
    logic [ADDR_WIDTH-1:0] ex_rd;
    logic [DATA_WIDTH-1:0] ex_result;
    logic                  ex_is_load;
    logic [1:0]            ex_ld_size;
    logic                  ex_ld_unsigned;
    logic [1:0]            ex_addr_lo;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rsp_data;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  err;

    modport master (
        output ex_valid, ex_rd, ex_result, ex_is_load, ex_ld_size,
               ex_ld_unsigned, ex_addr_lo, mem_rsp_valid, mem_rsp_data,
        input  ex_ready, wen, waddr, wdata, err
    );

    modport slave (
        input  ex_valid, ex_rd, ex_result, ex_is_load, ex_ld_size,
               ex_ld_unsigned, ex_addr_lo, mem_rsp_valid, mem_rsp_data,
        output ex_ready, wen, waddr, wdata, err
    );
endinterface

// File: rtl/wb_unit_load_ext.sv
// load_ext: picks the addressed byte/half lane out of an aligned memory word
// and sign- or zero-extends it. Word and reserved sizes pass the word through.
module load_ext
    import npc_wb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] raw_i,
    input  ld_size_e              size_i,
    input  logic                  is_unsigned_i,
    input  logic [1:0]            addr_lo_i,
    output logic [DATA_WIDTH-1:0] data_o
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sign_v;

    // Lane select and extension
    always_comb begin
        byte_v = raw_i[8*addr_lo_i +: 8];
        half_v = raw_i[16*addr_lo_i[1] +: 16];
        sign_v = 1'b0;
        data_o = raw_i;
        case (size_i)
            LD_BYTE: begin
                sign_v = !is_unsigned_i && byte_v[7];
                data_o = {{(DATA_WIDTH-8){sign_v}}, byte_v};
            end
            LD_HALF: begin
                sign_v = !is_unsigned_i && half_v[15];
                data_o = {{(DATA_WIDTH-16){sign_v}}, half_v};
            end
            default: data_o = raw_i;
        endcase
    end
endmodule

// File: rtl/wb_unit.sv
// wb_unit: writeback stage. ALU results are written one cycle after
// acceptance; loads park in WAIT_MEM until the memory response arrives.
// Optional feature macro: WB_BYPASS_EN adds a combinational forwarding port.
//
//   state      | meaning
//   -----------+--------------------------------------------------
//   S_IDLE     | ready for a new instruction (ex_ready=1)
//   S_WAIT_MEM | load accepted, waiting for mem_rsp_valid
module wb_unit
    import npc_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef WB_BYPASS_EN
    input  logic [ADDR_WIDTH-1:0] byp_rs,
    output logic                  byp_hit,
    output logic [DATA_WIDTH-1:0] byp_data,
`endif
    wb_unit_if.slave              bus
);
    wb_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    ld_size_e              size_q, size_d;
    logic                  uns_q, uns_d;
    logic [1:0]            alo_q, alo_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic                  wr_fire;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] ext_data;
    ld_size_e              ex_size;

    assign ex_size = ld_size_e'(bus.ex_ld_size);

    load_ext #(.DATA_WIDTH(DATA_WIDTH)) u_load_ext (
        .raw_i         (bus.mem_rsp_data),
        .size_i        (size_q),
        .is_unsigned_i (uns_q),
        .addr_lo_i     (alo_q),
        .data_o        (ext_data)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (bus.ex_valid && bus.ex_is_load) state_d = S_WAIT_MEM;
            S_WAIT_MEM: if (bus.mem_rsp_valid)              state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // FSM outputs and writeback next values; rd==0 completes without a write
    always_comb begin
        rd_d    = rd_q;
        size_d  = size_q;
        uns_d   = uns_q;
        alo_d   = alo_q;
        err_d   = err_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wr_fire = 1'b0;
        wr_addr = rd_q;
        wr_data = ext_data;
        case (state_q)
            S_IDLE: begin
                if (bus.mem_rsp_valid) err_d = 1'b1;
                if (bus.ex_valid) begin
                    if (!bus.ex_is_load) begin
                        wr_fire = 1'b1;
                        wr_addr = bus.ex_rd;
                        wr_data = bus.ex_result;
                    end else begin
                        rd_d   = bus.ex_rd;
                        size_d = ex_size;
                        uns_d  = bus.ex_ld_unsigned;
                        alo_d  = bus.ex_addr_lo;
                        if (ex_size == LD_RSVD || (ex_size == LD_HALF && bus.ex_addr_lo[0]))
                            err_d = 1'b1;
                    end
                end
            end
            S_WAIT_MEM: wr_fire = bus.mem_rsp_valid;
            default: ;
        endcase
        wen_d = wr_fire && (wr_addr != '0);
        if (wen_d) begin
            waddr_d = wr_addr;
            wdata_d = wr_data;
        end
    end

    // Writeback and latched-load registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            size_q  <= LD_BYTE;
            uns_q   <= 1'b0;
            alo_q   <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            alo_q   <= alo_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.ex_ready = (state_q == S_IDLE);
    assign bus.wen      = wen_q;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;
    assign bus.err      = err_q;

`ifdef WB_BYPASS_EN
    assign byp_hit  = wen_q && (waddr_q == byp_rs) && (byp_rs != '0);
    assign byp_data = wdata_q;
`endif
endmodule

// File: tb/tb_wb_unit.sv
// Testbench for wb_unit: directed cases plus random ALU/load traffic.
// Expected register writes are queued with the cycle they must appear in;
// a negedge monitor pops and compares them against the write port.
module tb_wb_unit;
    import npc_wb_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wb_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef WB_BYPASS_EN
    logic [AW-1:0] byp_rs;
    logic          byp_hit;
    logic [DW-1:0] byp_data;
`endif

    wb_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef WB_BYPASS_EN
        .byp_rs   (byp_rs),
        .byp_hit  (byp_hit),
        .byp_data (byp_data),
`endif
        .bus      (bus)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    int            n_chk = 0;
    int            n_pass = 0;
    bit            exp_err = 1'b0;
    logic [AW-1:0] last_a = '0;
    logic [DW-1:0] last_d = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference load extension: shift the lane down, mask, and sign-extend arithmetically
    function automatic logic [DW-1:0] ref_ext(input logic [DW-1:0] raw, input logic [1:0] size,
                                              input bit uns, input logic [1:0] alo);
        int     bits;
        int     lane;
        longint v;
        if (size == 2'd0) begin
            bits = 8;
            lane = int'(alo);
        end else if (size == 2'd1) begin
            bits = 16;
            lane = alo[1] ? 2 : 0;
        end else begin
            return raw;
        end
        v = longint'((64'(raw) >> (8 * lane)) & ((64'd1 << bits) - 64'd1));
        if (!uns && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
        return DW'(v);
    endfunction

    task automatic expect_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int at);
        exp_t e;
        if (a != '0) begin
            e.a = a; e.d = d; e.cyc = at;
            sb.push_back(e);
            last_a = a;
            last_d = d;
        end
    endtask

    // Monitor: each cycle the write port must match the scoreboard head or be idle
    always @(negedge clk) begin
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                chk("write_missing", 64'(cyc), 64'(sb[0].cyc));
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                chk("wen", 64'(bus.wen), 64'd1);
                chk("waddr", 64'(bus.waddr), 64'(sb[0].a));
                chk("wdata", 64'(bus.wdata), 64'(sb[0].d));
                void'(sb.pop_front());
            end else begin
                chk("wen_idle", 64'(bus.wen), 64'd0);
            end
        end
    end

    task automatic do_alu(input logic [AW-1:0] rd, input logic [DW-1:0] res);
        chk("ready_alu", 64'(bus.ex_ready), 64'd1);
        bus.ex_valid   = 1'b1;
        bus.ex_is_load = 1'b0;
        bus.ex_rd      = rd;
        bus.ex_result  = res;
        bus.ex_ld_size = 2'($urandom_range(0, 3));
        bus.ex_addr_lo = 2'($urandom_range(0, 3));
        expect_write(rd, res, cyc + 1);
        @(posedge clk); #1;
        bus.ex_valid = 1'b0;
    endtask

    task automatic do_load(input logic [AW-1:0] rd, input logic [1:0] size, input bit uns,
                           input logic [1:0] alo, input logic [DW-1:0] raw, input int wait_n);
        chk("ready_load", 64'(bus.ex_ready), 64'd1);
        bus.ex_valid       = 1'b1;
        bus.ex_is_load     = 1'b1;
        bus.ex_rd          = rd;
        bus.ex_result      = DW'($urandom);
        bus.ex_ld_size     = size;
        bus.ex_ld_unsigned = uns;
        bus.ex_addr_lo     = alo;
        if (size == 2'd3 || (size == 2'd1 && alo[0])) exp_err = 1'b1;
        @(posedge clk); #1;
        bus.ex_valid   = 1'b0;
        bus.ex_rd      = AW'($urandom);
        bus.ex_addr_lo = 2'($urandom_range(0, 3));
        for (int i = 0; i < wait_n; i++) begin
            chk("ready_wait", 64'(bus.ex_ready), 64'd0);
            @(posedge clk); #1;
        end
        chk("ready_wait", 64'(bus.ex_ready), 64'd0);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = raw;
        expect_write(rd, ref_ext(raw, size, uns, alo), cyc + 1);
        @(posedge clk); #1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = DW'($urandom);
        chk("ready_after_rsp", 64'(bus.ex_ready), 64'd1);
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, "_ready"}, 64'(bus.ex_ready), 64'd1);
        chk({nm, "_wen"},   64'(bus.wen),      64'd0);
        chk({nm, "_waddr"}, 64'(bus.waddr),    64'd0);
        chk({nm, "_wdata"}, 64'(bus.wdata),    64'd0);
        chk({nm, "_err"},   64'(bus.err),      64'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check_reset_state("reset");
        sb.delete();
        exp_err = 1'b0;
        last_a  = '0;
        last_d  = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.ex_valid       = 1'b0;
        bus.ex_rd          = '0;
        bus.ex_result      = '0;
        bus.ex_is_load     = 1'b0;
        bus.ex_ld_size     = 2'd0;
        bus.ex_ld_unsigned = 1'b0;
        bus.ex_addr_lo     = 2'd0;
        bus.mem_rsp_valid  = 1'b0;
        bus.mem_rsp_data   = '0;
`ifdef WB_BYPASS_EN
        byp_rs = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("por");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ALU write, rd=5
`ifdef WB_BYPASS_EN
        byp_rs = 5'd5;
`endif
        do_alu(5'd5, 32'h1234_5678);
`ifdef WB_BYPASS_EN
        chk("byp_hit", 64'(byp_hit), 64'd1);
        chk("byp_data", 64'(byp_data), 64'h1234_5678);
`endif
        @(posedge clk); #1;
`ifdef WB_BYPASS_EN
        chk("byp_hit_idle", 64'(byp_hit), 64'd0);
        byp_rs = '0;
`endif

        // Signed byte load from lane 3, response after 4 idle cycles
        do_load(5'd7, 2'd0, 1'b0, 2'd3, 32'h80AA_BBCC, 4);
        chk("byte_model", 64'(ref_ext(32'h80AA_BBCC, 2'd0, 1'b0, 2'd3)), 64'hFFFF_FF80);
        @(posedge clk); #1;

        // Unsigned half load from upper lane
        do_load(5'd8, 2'd1, 1'b1, 2'd2, 32'hBEEF_0000, 1);
        @(posedge clk); #1;

        // x0 target then rd=1, back-to-back; x0 leaves the write port holding
        do_alu(5'd0, 32'hCAFE_F00D);
        chk("hold_waddr", 64'(bus.waddr), 64'(last_a));
        chk("hold_wdata", 64'(bus.wdata), 64'(last_d));
        do_alu(5'd1, 32'h0000_0042);
        chk("ready_b2b", 64'(bus.ex_ready), 64'd1);
        @(posedge clk); #1;
        chk("err_clean", 64'(bus.err), 64'd0);

        // Response while idle: ignored, sets err
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h5555_AAAA;
        @(posedge clk); #1;
        bus.mem_rsp_valid = 1'b0;
        chk("err_rsp_idle", 64'(bus.err), 64'd1);
        @(posedge clk); #1;
        chk("err_sticky", 64'(bus.err), 64'd1);

        // Reset while waiting for memory abandons the load
        bus.ex_valid       = 1'b1;
        bus.ex_is_load     = 1'b1;
        bus.ex_rd          = 5'd9;
        bus.ex_ld_size     = 2'd2;
        bus.ex_addr_lo     = 2'd0;
        @(posedge clk); #1;
        bus.ex_valid = 1'b0;
        chk("ready_in_wait", 64'(bus.ex_ready), 64'd0);
        apply_reset();
        @(posedge clk); #1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h1111_2222;
        @(posedge clk); #1;
        bus.mem_rsp_valid = 1'b0;
        chk("err_late_rsp", 64'(bus.err), 64'd1);
        @(posedge clk); #1;

        // Reserved size: written as word, flags err
        apply_reset();
        do_load(5'd9, 2'd3, 1'b0, 2'd2, 32'hDEAD_BEEF, 1);
        chk("err_rsvd", 64'(bus.err), 64'd1);
        @(posedge clk); #1;

        // Misaligned half: lane from addr_lo[1], flags err
        apply_reset();
        do_load(5'd10, 2'd1, 1'b0, 2'd3, 32'h8001_2345, 0);
        chk("err_half_mis", 64'(bus.err), 64'd1);
        @(posedge clk); #1;

        // Random traffic
        apply_reset();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0)
                do_alu(AW'($urandom_range(0, 31)), DW'($urandom));
            else
                do_load(AW'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                        DW'($urandom), $urandom_range(0, 3));
            chk("err_random", 64'(bus.err), 64'(exp_err));
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/wb_unit.md
WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register-index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ex_valid  input  1  execute stage presents a completing instruction.
REQ-006 SHALL have port ex_ready  output  1  unit accepts the instruction this cycle.
REQ-007 SHALL have port ex_rd  input  ADDR_WIDTH  destination register index.
REQ-008 SHALL have port ex_result  input  DATA_WIDTH  ALU result for non-loads.
REQ-009 SHALL have port ex_is_load  input  1  instruction needs a memory response.
REQ-010 SHALL have port ex_ld_size  input  2  0=byte, 1=half, 2=word, 3=reserved.
REQ-011 SHALL have port ex_ld_unsigned  input  1  zero-extend instead of sign-extend.
REQ-012 SHALL have port ex_addr_lo  input  2  load address bits [1:0].
REQ-013 SHALL have port mem_rsp_valid  input  1  load data returned this cycle.
REQ-014 SHALL have port mem_rsp_data  input  DATA_WIDTH  raw aligned memory word.
REQ-015 SHALL have port wen  output  1  register-file write enable, registered.
REQ-016 SHALL have port waddr  output  ADDR_WIDTH  register-file write index, registered.
REQ-017 SHALL have port wdata  output  DATA_WIDTH  register-file write data, registered.
REQ-018 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-019 SHALL implement FSM states IDLE and WAIT_MEM; ex_ready = (state==IDLE).
REQ-020 SHALL, in IDLE on ex_valid with ex_is_load=0, assert wen next cycle with waddr=ex_rd and wdata=ex_result (latency 1), staying in IDLE.
REQ-021 SHALL, in IDLE on ex_valid with ex_is_load=1, latch rd/size/unsigned/addr_lo and go to WAIT_MEM; wen=0 next cycle.
REQ-022 SHALL, in WAIT_MEM on mem_rsp_valid, assert wen next cycle with extended load data and return to IDLE; ex_ready high in that same cycle.
REQ-023 SHALL remain in WAIT_MEM indefinitely while mem_rsp_valid=0, holding wen=0.
REQ-024 SHALL extend loads: byte lane = addr_lo, half lane = addr_lo[1], word ignores addr_lo; sign bit from lane MSB unless unsigned.
REQ-025 SHALL pulse wen for exactly one cycle per accepted instruction; never assert wen when rd==0, while still completing the handshake.
REQ-026 SHALL set err on: mem_rsp_valid in IDLE (response ignored), ex_ld_size==3 (written as word), or half load with addr_lo[0]=1 (lane per REQ-024); err clears only on reset.
REQ-027 SHALL hold waddr/wdata at last written values when wen=0.

Reset
REQ-028 SHALL, on rst_n low, asynchronously force state=IDLE, wen=0, waddr=0, wdata=0, err=0, latched fields 0.
REQ-029 SHALL, on reset during WAIT_MEM, abandon the load; a later mem_rsp_valid sets err per REQ-026.

Configuration
REQ-030 SHALL, with WB_BYPASS_EN defined, add input byp_rs (ADDR_WIDTH) and outputs byp_hit (1), byp_data (DATA_WIDTH): byp_hit = wen && waddr==byp_rs && byp_rs!=0, byp_data = wdata, combinational.
REQ-031 SHALL, without WB_BYPASS_EN, omit those ports with all other behaviour identical.

Structure
REQ-032 SHALL place the ld_size encoding, FSM state enum and default widths in shared package npc_wb_pkg.
REQ-033 SHALL implement extension in combinational sub-module load_ext (inputs raw word, size, unsigned, addr_lo; output extended data).

Verification
REQ-034 SHALL cover ALU write: ex_valid, rd=5, result=0x1234_5678 -> next cycle wen=1, waddr=5, wdata=0x1234_5678, then wen=0.
REQ-035 SHALL cover signed byte load: addr_lo=3, size=0, signed, rsp 0x80AA_BBCC after 4 idle cycles -> ex_ready=0 throughout wait, then wdata=0xFFFF_FF80.
REQ-036 SHALL cover unsigned half load: addr_lo=2, size=1, unsigned, rsp 0xBEEF_0000 -> wdata=0x0000_BEEF.
REQ-037 SHALL cover x0 target: back-to-back ALU ops rd=0 then rd=1 -> no wen for rd=0, wen for rd=1; ex_ready stays 1.
REQ-038 SHALL cover errors/reset: mem_rsp_valid in IDLE -> err=1, no wen; rst_n low in WAIT_MEM -> IDLE, err=0, wen=0.
REQ-039 SHALL cover, with WB_BYPASS_EN, byp_rs=5 during REQ-034 write cycle -> byp_hit=1, byp_data=0x1234_5678.
